inst_fetch_q: RTL
=================

INST_FETCH_Q -- requirements
Module: inst_fetch_q

Interface
REQ-001 Parameter DEPTH, default 4, number of 32-bit queue entries; power of two, 2..16.
REQ-002 Parameter RESET_PC, default 16'h0000, first fetch address after reset.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 fetch_req  output  1  memory read request, held until mem_ready.
REQ-006 fetch_addr  output  16  word address of the current read; stable while fetch_req is high.
REQ-007 mem_ready  input  1  read data valid on bus_in this cycle; ends the request.
REQ-008 bus_in  input  16  memory read data.
REQ-009 flush  input  1  one-cycle pulse: discard queue, restart at flush_addr.
REQ-010 flush_addr  input  16  new fetch address, sampled when flush is high.
REQ-011 ir  output  32  instruction presented to the execution unit.
REQ-012 sel_eu  output  2  decoded class: 00 arith_i, 01 arith.
REQ-013 cs  output  1  one-cycle dispatch strobe to the execution unit.
REQ-014 ready1  input  1  execution unit idle/complete indication.
REQ-015 q_count  output  log2(DEPTH)+1  current queue occupancy.
REQ-016 illegal  output  1  illegal-class flag (see Configuration).

Function
REQ-017 Fetch FSM states F_IDLE, F_LO, F_HI, F_PUSH shall be used.
REQ-018 F_IDLE shall go to F_LO when q_count < DEPTH, else remain (full stall).
REQ-019 F_LO shall drive fetch_req=1, fetch_addr=pc; on mem_ready it shall capture bus_in into ir[15:0] staging and go to F_HI.
REQ-020 F_HI shall drive fetch_req=1, fetch_addr=pc+1; on mem_ready it shall capture bus_in into staging ir[31:16] and go to F_PUSH.
REQ-021 F_PUSH shall write staging to the queue tail, set pc=pc+2 (16-bit modulo, 16'hFFFE+2=16'h0000, 16'hFFFF+1=16'h0000 for fetch_addr) and return to F_IDLE.
REQ-022 Decode shall use ir[31:30]: 00 gives sel_eu=00, 01 gives sel_eu=01, 10/11 illegal.
REQ-023 Dispatch FSM states D_IDLE, D_ISSUE, D_BUSY, D_DONE shall be used.
REQ-024 D_IDLE shall, when queue non-empty, ready1=1 and head legal, load ir/sel_eu from head and go to D_ISSUE.
REQ-025 D_ISSUE shall assert cs for exactly one cycle, then go to D_BUSY.
REQ-026 D_BUSY shall wait for ready1=0, then go to D_DONE; D_DONE shall wait for ready1=1, pop the head, and go to D_IDLE.
REQ-027 ir and sel_eu shall stay constant from D_ISSUE until the pop.
REQ-028 Push and pop in the same cycle shall leave q_count unchanged; pointers wrap modulo DEPTH.
REQ-029 Empty queue: no cs; full queue: fetch_req stays 0.
REQ-030 Flush shall, next edge, empty the queue, abort any fetch (late mem_ready data discarded), set pc=flush_addr and enter F_IDLE; a dispatched instruction in D_BUSY/D_DONE completes and is not popped twice.
REQ-031 Flush in the same cycle as a push shall win: the pushed word is discarded.
REQ-032 Minimum dispatch latency: cs one cycle after first push into an empty queue.

Reset
REQ-033 On rst_n=0: fetch_req=0, fetch_addr=RESET_PC, pc=RESET_PC, cs=0, ir=0, sel_eu=00, q_count=0, illegal=0, FSMs in F_IDLE/D_IDLE.
REQ-034 Reset mid-request shall drop the request immediately; release resumes fetch at RESET_PC.

Configuration
REQ-035 Macro ILLEGAL_TRAP_EN defined: illegal head sets illegal=1 (sticky), halts dispatch and fetch until flush, which clears it.
REQ-036 Macro ILLEGAL_TRAP_EN undefined: illegal head is popped silently in one cycle without cs; illegal tied 0.

Verification
REQ-037 Reset, memory returns 16'h1234 then 16'h0005 (addr 0,1) -> ir=32'h00051234, sel_eu=00, one cs pulse.
REQ-038 ready1 held 1, memory always ready -> queue fills to DEPTH=4, fetch_req=0 until first pop.
REQ-039 flush with flush_addr=16'h0100 during F_HI -> queued words discarded, next fetch_addr=16'h0100.
REQ-040 pc=16'hFFFE -> fetches FFFE, FFFF, then 0000.
REQ-041 Head ir[31:30]=2'b10 -> with ILLEGAL_TRAP_EN illegal=1 and no cs; without, discarded, next instruction dispatched.
REQ-042 rst_n low during D_BUSY -> cs=0, q_count=0, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/inst_fetch_q.sv
// inst_fetch_q: 16-bit memory fetch into a queue of 32-bit instructions,
// with a dispatch handshake toward one execution unit.
// Optional feature macro: ILLEGAL_TRAP_EN. When it is defined, an illegal
// head instruction traps (sticky flag, fetch and dispatch halt until flush).
// When it is undefined, an illegal head is dropped silently.
module inst_fetch_q #(
  parameter int          DEPTH    = 4,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic                   fetch_req,
  output logic [15:0]            fetch_addr,
  input  logic                   mem_ready,
  input  logic [15:0]            bus_in,
  input  logic                   flush,
  input  logic [15:0]            flush_addr,
  output logic [31:0]            ir,
  output logic [1:0]             sel_eu,
  output logic                   cs,
  input  logic                   ready1,
  output logic [$clog2(DEPTH):0] q_count,
  output logic                   illegal
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {F_IDLE, F_LO, F_HI, F_PUSH} f_state_t;
  typedef enum logic [1:0] {D_IDLE, D_ISSUE, D_BUSY, D_DONE} d_state_t;

  // Classes 00 (arith_i) and 01 (arith) are executable; 10/11 are not.
  function automatic logic class_legal(input logic [1:0] cls);
    logic ok;
    case (cls)
      2'b00:   ok = 1'b1;
      2'b01:   ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  f_state_t        f_state_r, f_next_s;
  d_state_t        d_state_r, d_next_s;
  logic [15:0]     pc_r, pc_next_s;
  logic [15:0]     stage_lo_r, stage_lo_next_s;
  logic [15:0]     stage_hi_r, stage_hi_next_s;
  logic            fetch_req_r, fetch_req_next_s;
  logic [15:0]     fetch_addr_r, fetch_addr_next_s;
  logic [31:0]     ir_r;
  logic [1:0]      sel_eu_r;
  logic            cs_r;
  logic            inflight_r;
  logic            push_s, pop_s, load_s, halt_s;
  logic [31:0]     mem_r [DEPTH];
  logic [PW-1:0]   wr_ptr_r, rd_ptr_r;
  logic [CW-1:0]   q_count_r;
  logic [31:0]     head_s;

  assign head_s     = mem_r[rd_ptr_r];
  assign fetch_req  = fetch_req_r;
  assign fetch_addr = fetch_addr_r;
  assign ir         = ir_r;
  assign sel_eu     = sel_eu_r;
  assign cs         = cs_r;
  assign q_count    = q_count_r;

`ifdef ILLEGAL_TRAP_EN
  logic illegal_r;
  logic set_illegal_s;
  assign halt_s  = illegal_r;
  assign illegal = illegal_r;

  // Sticky trap flag: set by an illegal head, cleared only by flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_r <= 1'b0;
    end else if (flush) begin
      illegal_r <= 1'b0;
    end else if (set_illegal_s) begin
      illegal_r <= 1'b1;
    end
  end
`else
  assign halt_s  = 1'b0;
  assign illegal = 1'b0;
`endif

  // Fetch FSM next state, pc and staging; flush overrides everything.
  always_comb begin
    f_next_s        = f_state_r;
    pc_next_s       = pc_r;
    stage_lo_next_s = stage_lo_r;
    stage_hi_next_s = stage_hi_r;
    push_s          = 1'b0;
    if (flush) begin
      f_next_s  = F_IDLE;
      pc_next_s = flush_addr;
    end else begin
      case (f_state_r)
        F_IDLE: begin
          if ((q_count_r < CW'(DEPTH)) && !halt_s) begin
            f_next_s = F_LO;
          end else begin
            f_next_s = F_IDLE;
          end
        end
        F_LO: begin
          if (mem_ready) begin
            stage_lo_next_s = bus_in;
            f_next_s        = F_HI;
          end else begin
            f_next_s = F_LO;
          end
        end
        F_HI: begin
          if (mem_ready) begin
            stage_hi_next_s = bus_in;
            f_next_s        = F_PUSH;
          end else begin
            f_next_s = F_HI;
          end
        end
        F_PUSH: begin
          push_s    = 1'b1;
          pc_next_s = pc_r + 16'd2;
          f_next_s  = F_IDLE;
        end
        default: f_next_s = F_IDLE;
      endcase
    end
    // The bus outputs are registered, so they are derived from the next state.
    fetch_req_next_s = (f_next_s == F_LO) || (f_next_s == F_HI);
    if (f_next_s == F_HI) begin
      fetch_addr_next_s = pc_next_s + 16'd1;
    end else begin
      fetch_addr_next_s = pc_next_s;
    end
  end

  // Dispatch FSM next state; flush blocks new dispatches but lets one in flight finish.
  always_comb begin
    d_next_s = d_state_r;
    pop_s    = 1'b0;
    load_s   = 1'b0;
`ifdef ILLEGAL_TRAP_EN
    set_illegal_s = 1'b0;
`endif
    case (d_state_r)
      D_IDLE: begin
        if (!flush && (q_count_r != CW'(0)) && !halt_s) begin
          if (class_legal(head_s[31:30])) begin
            if (ready1) begin
              load_s   = 1'b1;
              d_next_s = D_ISSUE;
            end else begin
              d_next_s = D_IDLE;
            end
          end else begin
`ifdef ILLEGAL_TRAP_EN
            set_illegal_s = 1'b1;
`else
            pop_s = 1'b1;
`endif
          end
        end else begin
          d_next_s = D_IDLE;
        end
      end
      D_ISSUE: d_next_s = D_BUSY;
      D_BUSY: begin
        if (!ready1) begin
          d_next_s = D_DONE;
        end else begin
          d_next_s = D_BUSY;
        end
      end
      D_DONE: begin
        if (ready1) begin
          d_next_s = D_IDLE;
          // A flush since dispatch already removed this entry.
          pop_s    = inflight_r && !flush;
        end else begin
          d_next_s = D_DONE;
        end
      end
      default: d_next_s = D_IDLE;
    endcase
  end

  // State registers and registered outputs for both FSMs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_state_r    <= F_IDLE;
      d_state_r    <= D_IDLE;
      pc_r         <= RESET_PC;
      stage_lo_r   <= 16'h0000;
      stage_hi_r   <= 16'h0000;
      fetch_req_r  <= 1'b0;
      fetch_addr_r <= RESET_PC;
      ir_r         <= 32'h0000_0000;
      sel_eu_r     <= 2'b00;
      cs_r         <= 1'b0;
      inflight_r   <= 1'b0;
    end else begin
      f_state_r    <= f_next_s;
      d_state_r    <= d_next_s;
      pc_r         <= pc_next_s;
      stage_lo_r   <= stage_lo_next_s;
      stage_hi_r   <= stage_hi_next_s;
      fetch_req_r  <= fetch_req_next_s;
      fetch_addr_r <= fetch_addr_next_s;
      cs_r         <= (d_next_s == D_ISSUE);
      if (load_s) begin
        ir_r       <= head_s;
        sel_eu_r   <= head_s[31:30];
        inflight_r <= 1'b1;
      end else if (flush || pop_s) begin
        inflight_r <= 1'b0;
      end
    end
  end

  // Circular instruction queue; flush empties it and drops a same-cycle push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r  <= '0;
      rd_ptr_r  <= '0;
      q_count_r <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= 32'h0000_0000;
      end
    end else if (flush) begin
      wr_ptr_r  <= '0;
      rd_ptr_r  <= '0;
      q_count_r <= '0;
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= {stage_hi_r, stage_lo_r};
        wr_ptr_r        <= wr_ptr_r + PW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   q_count_r <= q_count_r + CW'(1);
        2'b01:   q_count_r <= q_count_r - CW'(1);
        default: q_count_r <= q_count_r;
      endcase
    end
  end

endmodule
